// File: rtl/systolic_result_collector.sv
// ---------------------------------------------------------------------------
// systolic_result_collector
//
// Collects partial sums from the bottom edge of a weight-stationary systolic
// array. Column j's result for a row arrives j cycles after column 0's. Each
// column is delayed by COLS-1-j register stages so the whole row lines up. The
// aligned rows go into a FIFO, which feeds a valid/ready output. A registered
// `hold` asks the array sequencer to stop injecting rows while the FIFO still
// has room for the rows already inside the deskew pipe.
//
// Parameters:
//   DATA_WIDTH  PE operand width; each sum is ACC_W = 2*DATA_WIDTH bits
//   COLS        array columns (>= 2)
//   FIFO_DEPTH  row entries (power of two, >= 2*COLS)
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    column 0 carries a valid sum this cycle
//   in_data     bottom-row sums; column j at [j*ACC_W +: ACC_W]
//   out_valid   aligned row available (FIFO not empty)
//   out_ready   downstream accepts the head row
//   out_data    head row, same packing as in_data (0 when empty)
//   hold        registered: sequencer must stop issuing rows
//   overflow    sticky: a row was dropped because the FIFO was full
//   count       FIFO occupancy
//   rows_done   (SYSTOLIC_COLLECT_STATS_EN only) wrapping 16-bit pop counter
//
// Optional feature macro: SYSTOLIC_COLLECT_STATS_EN
// ---------------------------------------------------------------------------

// Fixed-delay register lane with no stall. DELAY may be 0, which gives a
// plain wire.
module systolic_deskew_lane #(
    parameter int W     = 16,
    parameter int DELAY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (DELAY == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign q = d;
        end else begin : g_pipe
            logic [DELAY-1:0][W-1:0] pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign q = pipe[DELAY-1];
        end
    endgenerate
endmodule

module systolic_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [COLS*2*DATA_WIDTH-1:0]       in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COLS*2*DATA_WIDTH-1:0]       out_data,
    output logic                               hold,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH):0]        count
`ifdef SYSTOLIC_COLLECT_STATS_EN
    ,
    output logic [15:0]                        rows_done
`endif
);
    localparam int ACC_W = 2 * DATA_WIDTH;
    localparam int ROW_W = COLS * ACC_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
    // COLS entries of headroom cover the rows that are still in the deskew pipe.
    localparam logic [CW-1:0] HOLD_LVL = CW'(FIFO_DEPTH - COLS);

    // ---------------- deskew ----------------
    logic [COLS-1:0][ACC_W-1:0] row_data;
    logic                       row_valid;

    genvar j;
    generate
        for (j = 0; j < COLS; j++) begin : g_lane
            systolic_deskew_lane #(.W(ACC_W), .DELAY(COLS - 1 - j)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (in_data[j*ACC_W +: ACC_W]),
                .q     (row_data[j])
            );
        end
    endgenerate

    // The valid bit follows column 0, so it sees the longest delay.
    systolic_deskew_lane #(.W(1), .DELAY(COLS - 1)) u_vld (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_valid),
        .q     (row_valid)
    );

    // ---------------- FIFO ----------------
    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, pop, push_ok, drop;

    assign out_valid = (count != '0);
    assign full      = (count == FULL_LVL);
    assign pop       = out_valid && out_ready;
    // When the FIFO is full, a push still fits if the head leaves in the same cycle.
    assign push_ok   = row_valid && (!full || pop);
    assign drop      = row_valid && full && !pop;
    // Gate the head with occupancy so out_data reads 0 when the FIFO is empty.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage needs no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= row_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            hold     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (drop)    overflow <= 1'b1;
            hold <= (count >= HOLD_LVL);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SYSTOLIC_COLLECT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rows_done <= '0;
        else if (pop) rows_done <= rows_done + 16'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_result_collector.sv
// ---------------------------------------------------------------------------
// Testbench for systolic_result_collector (COLS=4, DATA_WIDTH=8, FIFO_DEPTH=8).
// The sequencer side issues whole rows. The bench skews each row onto in_data
// itself, so column j carries the row's value j cycles after issue. The
// reference model is a row queue of bounded capacity. Each issued row lands in
// the queue COLS-1 cycles after issue. A full queue drops the row unless the
// head leaves in the same cycle.
// ---------------------------------------------------------------------------
module tb_systolic_result_collector;
    localparam int COLS  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int ACC   = 2 * DW;
    localparam int RW    = COLS * ACC;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [RW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          hold;
    logic          overflow;
    logic [CW-1:0] count;
`ifdef SYSTOLIC_COLLECT_STATS_EN
    logic [15:0]   rows_done;
`endif

    systolic_result_collector #(.DATA_WIDTH(DW), .COLS(COLS), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .hold      (hold),
        .overflow  (overflow),
        .count     (count)
`ifdef SYSTOLIC_COLLECT_STATS_EN
        ,
        .rows_done (rows_done)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // reference model state
    logic [RW-1:0] mq[$];        // rows buffered, head first
    logic [RW-1:0] pend_dat[$];  // rows in flight towards the buffer
    int            pend_due[$];  // cycle at whose end each row lands
    logic [RW-1:0] popped[$];    // rows accepted downstream, in order
    bit            hv[COLS];     // skew history: row issued k cycles ago
    logic [RW-1:0] hd[COLS];
    bit            ovf_m, hold_m;
    logic [15:0]   rows_m;

    function automatic logic [RW-1:0] rnd_row();
        return {$urandom, $urandom};
    endfunction

    task automatic model_clear();
        mq.delete(); pend_dat.delete(); pend_due.delete();
        for (int k = 0; k < COLS; k++) begin hv[k] = 1'b0; hd[k] = '0; end
        ovf_m = 1'b0; hold_m = 1'b0; rows_m = '0;
        in_valid = 1'b0; in_data = '0;
    endtask

    // One clock cycle: drive the skewed inputs, advance the model across the
    // edge, and return 1 ns after the edge so outputs can be sampled.
    task automatic step(input bit iss, input logic [RW-1:0] row, input bit rdy);
        bit pop, push, hold_next;
        int sz;
        logic [RW-1:0] pd;
        for (int k = COLS - 1; k > 0; k--) begin hv[k] = hv[k-1]; hd[k] = hd[k-1]; end
        hv[0] = iss; hd[0] = row;
        in_valid = hv[0];
        for (int c = 0; c < COLS; c++)
            in_data[c*ACC +: ACC] = hv[c] ? hd[c][c*ACC +: ACC] : 16'($urandom);
        out_ready = rdy;
        if (iss) begin pend_due.push_back(cyc + COLS - 1); pend_dat.push_back(row); end
        sz        = mq.size();
        pop       = (sz != 0) && rdy;
        push      = (pend_due.size() != 0) && (pend_due[0] == cyc);
        hold_next = (sz >= DEPTH - COLS);
        @(posedge clk);
        if (pop) begin popped.push_back(mq.pop_front()); rows_m++; end
        if (push) begin
            pd = pend_dat.pop_front();
            void'(pend_due.pop_front());
            if (sz == DEPTH && !pop) ovf_m = 1'b1;
            else mq.push_back(pd);
        end
        hold_m = hold_next;
        cyc++;
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_clear();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else n_pass++;
        n_chk++; if (out_data !== '0) $display("FAIL reset_out_data got %h exp 0", out_data); else n_pass++;
        n_chk++; if (hold !== 1'b0) $display("FAIL reset_hold got %0b exp 0", hold); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b exp 0", overflow); else n_pass++;
        n_chk++; if (count !== '0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
`ifdef SYSTOLIC_COLLECT_STATS_EN
        n_chk++; if (rows_done !== 16'd0) $display("FAIL reset_rows_done got %0d exp 0", rows_done); else n_pass++;
`endif
        rst_n = 1'b1;
    endtask

    // Issue at cycle t: the row must be visible at t+4 for exactly one cycle.
    task automatic test_single_row();
        logic [RW-1:0] row;
        bit exp_v;
        row = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        for (int k = 0; k < 8; k++) begin
            step(k == 0, row, 1'b1);
            exp_v = (k == 3);
            n_chk++; if (out_valid !== exp_v) $display("FAIL single_valid k=%0d got %0b exp %0b", k, out_valid, exp_v); else n_pass++;
            if (exp_v) begin
                n_chk++; if (out_data !== row) $display("FAIL single_data got %h exp %h", out_data, row); else n_pass++;
            end
        end
        n_chk++; if (count !== '0) $display("FAIL single_count got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_streaming();
        logic [RW-1:0] sent[$];
        int vcyc = 0;
        popped.delete();
        for (int k = 0; k < 28; k++) begin
            if (k < 20) sent.push_back(rnd_row());
            step(k < 20, (k < 20) ? sent[k] : '0, 1'b1);
            if (out_valid === 1'b1) vcyc++;
            n_chk++; if (out_valid !== (mq.size() != 0)) $display("FAIL stream_valid k=%0d got %0b exp %0b", k, out_valid, mq.size() != 0); else n_pass++;
            if (mq.size() != 0) begin
                n_chk++; if (out_data !== mq[0]) $display("FAIL stream_data k=%0d got %h exp %h", k, out_data, mq[0]); else n_pass++;
            end
            n_chk++; if (hold !== 1'b0) $display("FAIL stream_hold k=%0d got %0b exp 0", k, hold); else n_pass++;
            n_chk++; if (overflow !== 1'b0) $display("FAIL stream_overflow k=%0d got %0b exp 0", k, overflow); else n_pass++;
            n_chk++; if (count !== CW'(mq.size())) $display("FAIL stream_count k=%0d got %0d exp %0d", k, count, mq.size()); else n_pass++;
        end
        n_chk++; if (vcyc != 20) $display("FAIL stream_valid_cycles got %0d exp 20", vcyc); else n_pass++;
        n_chk++; if (popped.size() != 20) $display("FAIL stream_rows got %0d exp 20", popped.size()); else n_pass++;
        for (int i = 0; i < 20 && i < popped.size(); i++) begin
            n_chk++; if (popped[i] !== sent[i]) $display("FAIL stream_order i=%0d got %h exp %h", i, popped[i], sent[i]); else n_pass++;
        end
`ifdef SYSTOLIC_COLLECT_STATS_EN
        n_chk++; if (rows_done !== rows_m) $display("FAIL stream_rows_done got %0d exp %0d", rows_done, rows_m); else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] sent[$];
        int guard = 0;
        popped.delete();
        // sequencer obeys hold: issue only while hold is low
        while (!hold_m && guard < 30) begin
            sent.push_back(rnd_row());
            step(1'b1, sent[sent.size()-1], 1'b0);
            guard++;
            n_chk++; if (hold !== hold_m) $display("FAIL bp_hold step=%0d got %0b exp %0b", guard, hold, hold_m); else n_pass++;
            n_chk++; if (count !== CW'(mq.size())) $display("FAIL bp_count step=%0d got %0d exp %0d", guard, count, mq.size()); else n_pass++;
        end
        n_chk++; if (!hold_m) $display("FAIL bp_hold_timeout got 0 exp 1"); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, 1'b0);
            n_chk++; if (hold !== hold_m) $display("FAIL bp_hold_idle k=%0d got %0b exp %0b", k, hold, hold_m); else n_pass++;
        end
        n_chk++; if (count !== CW'(sent.size())) $display("FAIL bp_landed got %0d exp %0d", count, sent.size()); else n_pass++;
        n_chk++; if (count > CW'(DEPTH)) $display("FAIL bp_count_max got %0d exp <=8", count); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL bp_overflow got %0b exp 0", overflow); else n_pass++;
        guard = 0;
        while (mq.size() != 0 && guard < 30) begin
            step(1'b0, '0, 1'b1);
            guard++;
            if (mq.size() != 0) begin
                n_chk++; if (out_data !== mq[0]) $display("FAIL bp_drain_data got %h exp %h", out_data, mq[0]); else n_pass++;
            end
        end
        n_chk++; if (count !== '0) $display("FAIL bp_drained_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (popped.size() != sent.size()) $display("FAIL bp_rows got %0d exp %0d", popped.size(), sent.size()); else n_pass++;
        for (int i = 0; i < sent.size() && i < popped.size(); i++) begin
            n_chk++; if (popped[i] !== sent[i]) $display("FAIL bp_order i=%0d got %h exp %h", i, popped[i], sent[i]); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [RW-1:0] sent[$];
        int guard = 0;
        reset_pulse();
        popped.delete();
        for (int k = 0; k < 14; k++) begin
            if (k < 9) sent.push_back(rnd_row());
            step(k < 9, (k < 9) ? sent[k] : '0, 1'b0);
            n_chk++; if (overflow !== ovf_m) $display("FAIL ovf_flag k=%0d got %0b exp %0b", k, overflow, ovf_m); else n_pass++;
        end
        n_chk++; if (count !== CW'(DEPTH)) $display("FAIL ovf_count got %0d exp 8", count); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b exp 1", overflow); else n_pass++;
        while (mq.size() != 0 && guard < 30) begin step(1'b0, '0, 1'b1); guard++; end
        n_chk++; if (popped.size() != 8) $display("FAIL ovf_rows got %0d exp 8", popped.size()); else n_pass++;
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            n_chk++; if (popped[i] !== sent[i]) $display("FAIL ovf_order i=%0d got %h exp %h", i, popped[i], sent[i]); else n_pass++;
        end
        n_chk++; if (count !== '0 || out_valid !== 1'b0) $display("FAIL ovf_ninth_absent count %0d valid %0b exp 0/0", count, out_valid); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", overflow); else n_pass++;
    endtask

    task automatic test_full_simul();
        logic [RW-1:0] sent[$];
        logic [RW-1:0] extra;
        int guard = 0;
        reset_pulse();
        popped.delete();
        for (int k = 0; k < 12; k++) begin
            if (k < 8) sent.push_back(rnd_row());
            step(k < 8, (k < 8) ? sent[k] : '0, 1'b0);
        end
        n_chk++; if (count !== CW'(DEPTH)) $display("FAIL full_fill got %0d exp 8", count); else n_pass++;
        extra = rnd_row();
        step(1'b1, extra, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);   // the extra row lands on this edge together with a pop
        n_chk++; if (count !== CW'(DEPTH)) $display("FAIL full_simul_count got %0d exp 8", count); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL full_simul_overflow got %0b exp 0", overflow); else n_pass++;
        n_chk++; if (out_data !== sent[1]) $display("FAIL full_simul_head got %h exp %h", out_data, sent[1]); else n_pass++;
        while (mq.size() != 0 && guard < 30) begin step(1'b0, '0, 1'b1); guard++; end
        sent.push_back(extra);
        n_chk++; if (popped.size() != 9) $display("FAIL full_rows got %0d exp 9", popped.size()); else n_pass++;
        for (int i = 0; i < 9 && i < popped.size(); i++) begin
            n_chk++; if (popped[i] !== sent[i]) $display("FAIL full_order i=%0d got %h exp %h", i, popped[i], sent[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, rnd_row(), 1'b0);
        step(1'b1, rnd_row(), 1'b0);
        step(1'b1, rnd_row(), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        n_chk++; if (count !== CW'(2)) $display("FAIL mid_pre_count got %0d exp 2", count); else n_pass++;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %0b exp 0", out_valid); else n_pass++;
        n_chk++; if (count !== '0) $display("FAIL mid_count got %0d exp 0", count); else n_pass++;
`ifdef SYSTOLIC_COLLECT_STATS_EN
        n_chk++; if (rows_done !== 16'd0) $display("FAIL mid_rows_done got %0d exp 0", rows_done); else n_pass++;
`endif
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b1);
            n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_stale k=%0d got %0b exp 0", k, out_valid); else n_pass++;
        end
        // a fresh row after release obeys the normal latency
        begin
            logic [RW-1:0] r;
            r = rnd_row();
            for (int k = 0; k < 5; k++) begin
                step(k == 0, r, 1'b1);
                if (k == 3) begin
                    n_chk++; if (out_valid !== 1'b1 || out_data !== r) $display("FAIL mid_after got %0b/%h exp 1/%h", out_valid, out_data, r); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_row();
        test_streaming();
        test_backpressure();
        test_overflow();
        test_full_simul();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/systolic_result_collector.md
# systolic_result_collector

Drains partial sums from the bottom edge of the weight-stationary systolic array. Column j's result emerges j cycles after column 0's, so this block deskews each row with per-column delay lines. It buffers aligned rows in a FIFO and presents them downstream on a valid/ready interface. A registered `hold` tells the array sequencer to stop injecting activations before the buffer can overflow.

## Interface
- `DATA_WIDTH`, default 8: PE operand width. Each sum is `ACC_W = 2*DATA_WIDTH` bits, matching PE `out_data`.
- `COLS`, default 4: array columns; must be ≥ 2.
- `FIFO_DEPTH`, default 8: row entries; must be a power of two and ≥ 2*COLS.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  column 0 carries a valid sum this cycle; column j's sum of the same row arrives exactly j cycles later.
- `in_data`  in  COLS*ACC_W  bottom-row PE sums; column j occupies bits [j*ACC_W +: ACC_W].
- `out_valid`  out  1  aligned row available.
- `out_ready`  in  1  downstream accepts the row.
- `out_data`  out  COLS*ACC_W  aligned row, same packing as `in_data`.
- `hold`  out  1  sequencer must stop issuing new rows.
- `overflow`  out  1  sticky: a row was dropped.
- `count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Deskew:
  - Column j passes through COLS-1-j register stages; column COLS-1 has none.
  - `in_valid` passes through COLS-1 stages.
  - Output of the deskew stage is one aligned row plus `row_valid`.
- Deskew registers shift every cycle and never stall. Backpressure is handled only through `hold`.
- FIFO push occurs on `row_valid`. Pop occurs on `out_valid && out_ready`.
- Push while full without a same-cycle pop:
  - the row is dropped;
  - `overflow` goes to 1 next cycle and stays 1 until reset;
  - FIFO contents are unchanged.
- Push while full with a same-cycle pop: the push is accepted and `count` stays at FIFO_DEPTH.
- Push while empty with `out_ready`=1: the row is written and becomes visible the next cycle. There is no bypass.
- `out_valid` = (`count` ≠ 0). `out_data` is the head entry, stable while `out_valid` && !`out_ready`.
- `hold` is registered. It equals 1 the cycle after `count` ≥ FIFO_DEPTH-COLS, otherwise 0. The headroom of COLS entries covers rows still in the deskew pipe.
- Arithmetic: none; sums are passed bit-exact, with no truncation or sign handling.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `hold`=0, `overflow`=0, `count`=0. All deskew stages and their valid bits are cleared.
- Reset asserted mid-operation discards all in-flight and buffered rows. The first row after release obeys the normal latency.
- Latency: `in_valid` at cycle t gives `row_valid` at t+COLS-1 and `out_valid` at t+COLS when the FIFO is empty.
- Throughput: one row per cycle sustained when `out_ready` is held at 1.
- `count` updates on the cycle after the push/pop event.

## Configuration
- `SYSTOLIC_COLLECT_STATS_EN` defined:
  - adds output `rows_done` (out, 16 bits, reset 0);
  - increments by 1 on every pop handshake;
  - wraps from 0xFFFF to 0x0000.
- Not defined: the port and its counter do not exist. All other behaviour is identical.

## Test plan
All scenarios use COLS=4, DATA_WIDTH=8, FIFO_DEPTH=8.
- Skewed single row, `out_ready`=1:
  - Stimulus: `in_valid` at t=10. Columns 0..3 carry 0x0011, 0x0022, 0x0033, 0x0044 at t=10, 11, 12, 13 respectively.
  - Required: `out_valid` at t=14, `out_data`=0x0044_0033_0022_0011 for exactly one cycle.
- Streaming: 20 back-to-back rows with `out_ready`=1 → 20 rows out in order on consecutive cycles; `hold` never asserts; `overflow`=0.
- Backpressure: `out_ready`=0 with rows issued until `hold` rises.
  - Required: `hold`=1 the cycle after `count` reaches 4.
  - Injection stops when `hold` rises; the rows in flight land; `count` ≤ 8; `overflow`=0.
  - Then `out_ready`=1 drains all rows in order.
- Overflow: `out_ready`=0, 9 rows issued ignoring `hold` → `count`=8, `overflow`=1; the 9th row is absent from the drained data.
- Full plus simultaneous events: FIFO full, push and pop in the same cycle → `count` stays 8, the pushed row appears last, `overflow` remains 0.
- Reset mid-flight: `rst_n` pulsed low while 2 rows are buffered and 1 is in deskew → `out_valid`=0 and `count`=0 immediately. No stale row appears afterwards. With the macro, `rows_done`=0.
